// File: rtl/ldpc_pkg.sv
// Shared types and defaults for the LDPC check-node datapath.
package ldpc_pkg;
  localparam int W_DEF   = 16;
  localparam int DEG_DEF = 8;
  localparam int IDX_W   = $clog2(DEG_DEF);

  typedef logic signed [W_DEF-1:0] msg_t;
  typedef logic        [W_DEF-2:0] mag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/cnu_lane.sv
// One min-sum lane: buffers a row of messages, tracks the two smallest
// magnitudes plus sign parity, and forms the extrinsic output for a write index.
module cnu_lane
  import ldpc_pkg::*;
#(
  parameter int          W      = W_DEF,
  parameter int          DEG    = DEG_DEF,
  parameter int unsigned OFFSET = 0,
  parameter int          IW     = $clog2(DEG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          cap_en,
  input  logic [IW-1:0] cap_idx,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  rd_data,
  output logic [W-1:0]  wr_data
);
  localparam logic [W-2:0] MAG_MAX = {(W-1){1'b1}};
  localparam logic [W-1:0] MSG_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-2:0] OFF     = OFFSET[W-2:0];

  logic [DEG-1:0][W-1:0] buf_q, buf_d;
  logic [W-2:0]          min1_q, min1_d, min2_q, min2_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  sgn_q, sgn_d;

  logic [W-1:0] neg_x;
  logic [W-2:0] mag;

  // The most negative input has no positive twin; clamp it to the largest magnitude.
  always_comb begin
    neg_x = -rd_data;
    if (rd_data == MSG_MIN)  mag = MAG_MAX;
    else if (rd_data[W-1])   mag = neg_x[W-2:0];
    else                     mag = rd_data[W-2:0];
  end

  always_comb begin
    buf_d  = buf_q;
    min1_d = min1_q;
    min2_d = min2_q;
    idx_d  = idx_q;
    sgn_d  = sgn_q;
    if (init) begin
      min1_d = MAG_MAX;
      min2_d = MAG_MAX;
      idx_d  = '0;
      sgn_d  = 1'b0;
    end else if (cap_en) begin
      buf_d[cap_idx] = rd_data;
      sgn_d          = sgn_q ^ rd_data[W-1];
      if (mag < min1_q) begin
        min2_d = min1_q;
        min1_d = mag;
        idx_d  = cap_idx;
      end else if (mag < min2_q) begin
        min2_d = mag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      min1_q <= '0;
      min2_q <= '0;
      idx_q  <= '0;
      sgn_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      min1_q <= min1_d;
      min2_q <= min2_d;
      idx_q  <= idx_d;
      sgn_q  <= sgn_d;
    end
  end

  logic [W-1:0] x_k;
  logic [W-2:0] m, m_off;
  logic         s;

  always_comb begin
    x_k   = buf_q[wr_idx];
    m     = (wr_idx == idx_q) ? min2_q : min1_q;
    m_off = (m > OFF) ? (m - OFF) : '0;
    s     = sgn_q ^ x_k[W-1];
    // Negating a zero magnitude gives zero, so no negative zero can appear.
    wr_data = s ? -{1'b0, m_off} : {1'b0, m_off};
  end
endmodule

// File: rtl/cnu_min_sum_pair.sv
// Two-lane offset min-sum check-node unit: read a row, compute, write it back.
module cnu_min_sum_pair
  import ldpc_pkg::*;
#(
  parameter int          W      = W_DEF,
  parameter int          DEG    = DEG_DEF,
  parameter int unsigned OFFSET = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         m_re,
  output logic         m_we,
  input  logic [W-1:0] m_rd_e,
  input  logic [W-1:0] m_rd_o,
  output logic [W-1:0] m_wr_e,
  output logic [W-1:0] m_wr_o
);
  localparam int          IW   = $clog2(DEG);
  localparam logic [IW-1:0] LAST = IW'(DEG - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] cap_q, cap_d;
  logic          rd_vld_q, rd_vld_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          m_re_q, m_re_d, m_we_q, m_we_d;
  logic          init;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_READ;
        cnt_d   = '0;
        init    = 1'b1;
      end
      ST_READ: if (cnt_q == LAST) begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      ST_WAIT: begin
        state_d = ST_WRITE;
        cnt_d   = '0;
      end
      ST_WRITE: if (cnt_q == LAST) begin
        state_d = ST_DONE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Read data lands one cycle after each strobe; capture index follows that lag.
    rd_vld_d = m_re_q;
    cap_d    = init ? '0 : (rd_vld_q ? cap_q + 1'b1 : cap_q);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    m_re_d   = (state_d == ST_READ);
    m_we_d   = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cap_q    <= '0;
      rd_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      m_re_q   <= 1'b0;
      m_we_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      rd_vld_q <= rd_vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      m_re_q   <= m_re_d;
      m_we_q   <= m_we_d;
    end
  end

  logic [1:0][W-1:0] rd_lane, wr_lane;
  assign rd_lane = {m_rd_o, m_rd_e};

  for (genvar l = 0; l < 2; l++) begin : g_lane
    cnu_lane #(.W(W), .DEG(DEG), .OFFSET(OFFSET), .IW(IW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .init    (init),
      .cap_en  (rd_vld_q),
      .cap_idx (cap_q),
      .wr_idx  (cnt_q),
      .rd_data (rd_lane[l]),
      .wr_data (wr_lane[l])
    );
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign m_re   = m_re_q;
  assign m_we   = m_we_q;
  assign m_wr_e = m_we_q ? wr_lane[0] : '0;
  assign m_wr_o = m_we_q ? wr_lane[1] : '0;
endmodule

// File: tb/tb_cnu_min_sum_pair.sv
// Bench for cnu_min_sum_pair: OFFSET=0 and OFFSET=1 instances share one memory model.
module tb_cnu_min_sum_pair;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  always #5 clk = ~clk;

  logic        busy0, done0, re0, we0, busy1, done1, re1, we1;
  logic [15:0] rd_e, rd_o, wr_e0, wr_o0, wr_e1, wr_o1;

  cnu_min_sum_pair #(.W(16), .DEG(8), .OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .m_re(re0), .m_we(we0), .m_rd_e(rd_e), .m_rd_o(rd_o),
    .m_wr_e(wr_e0), .m_wr_o(wr_o0));

  cnu_min_sum_pair #(.W(16), .DEG(8), .OFFSET(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .m_re(re1), .m_we(we1), .m_rd_e(rd_e), .m_rd_o(rd_o),
    .m_wr_e(wr_e1), .m_wr_o(wr_o1));

  logic signed [15:0] mem_e [8];
  logic signed [15:0] mem_o [8];
  int rptr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= 0; rd_e <= '0; rd_o <= '0;
    end else if (start && !busy0) begin
      rptr <= 0;
    end else if (re0) begin
      rd_e <= mem_e[rptr % 8];
      rd_o <= mem_o[rptr % 8];
      rptr <= rptr + 1;
    end
  end

  typedef struct {
    int in_e[8]; int in_o[8];
    int e0[8]; int o0[8]; int e1[8]; int o1[8];
  } vec_t;
  typedef struct { int e0; int o0; int e1; int o1; } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int s16(logic [15:0] x);
    return int'($signed(x));
  endfunction

  task automatic check_reset_outputs(string nm);
    chk({nm, "_ctrl"}, int'({busy0, done0, re0, we0, busy1, done1, re1, we1}), 0);
    chk({nm, "_data"}, int'(|{wr_e0, wr_o0, wr_e1, wr_o1}), 0);
  endtask

  // Runs one pass from the current negedge. smask bit r drives start in cycle r;
  // abort_rel > 0 pulses reset in that cycle and abandons the pass.
  task automatic run_pass(int v, logic [31:0] smask, int abort_rel);
    int   n_re = 0, n_we = 0, n_done = 0;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      mem_e[i] = 16'(vecs[v].in_e[i]);
      mem_o[i] = 16'(vecs[v].in_o[i]);
      e.e0 = vecs[v].e0[i]; e.o0 = vecs[v].o0[i];
      e.e1 = vecs[v].e1[i]; e.o1 = vecs[v].o1[i];
      sb.push_back(e);
    end
    start = 1'b1;
    for (int rel = 1; rel <= 19; rel++) begin
      logic b, d, r, w;
      @(negedge clk);
      b = (rel <= 18); d = (rel == 18);
      r = (rel >= 1 && rel <= 8); w = (rel >= 10 && rel <= 17);
      chk($sformatf("ctrl v%0d c%0d", v, rel),
          int'({busy0, done0, re0, we0, busy1, done1, re1, we1}),
          int'({b, d, r, w, b, d, r, w}));
      chk("re_we_excl", int'(re0 & we0), 0);
      n_re += int'(re0); n_we += int'(we0); n_done += int'(done0);
      if (we0) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk($sformatf("wr_e0 v%0d c%0d", v, rel), s16(wr_e0), e.e0);
          chk($sformatf("wr_o0 v%0d c%0d", v, rel), s16(wr_o0), e.o0);
          chk($sformatf("wr_e1 v%0d c%0d", v, rel), s16(wr_e1), e.e1);
          chk($sformatf("wr_o1 v%0d c%0d", v, rel), s16(wr_o1), e.o1);
        end
      end else begin
        chk($sformatf("wr_idle v%0d c%0d", v, rel), int'(|{wr_e0, wr_o0, wr_e1, wr_o1}), 0);
      end
      if (rel == abort_rel) begin
        rst = 1'b1;
        start = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        sb.delete();
        @(negedge clk);
        check_reset_outputs("abort_hold");
        rst = 1'b0;
        return;
      end
      start = smask[rel];
    end
    chk($sformatf("n_re v%0d", v), n_re, 8);
    chk($sformatf("n_we v%0d", v), n_we, 8);
    chk($sformatf("n_done v%0d", v), n_done, 1);
    chk($sformatf("sb_left v%0d", v), sb.size(), 0);
  endtask

  initial begin
    vecs[0].in_e = '{5, -3, 7, 2, -9, 4, 6, 8};
    vecs[0].in_o = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[0].e0   = '{2, -2, 2, 3, -2, 2, 2, 2};
    vecs[0].o0   = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[0].e1   = '{1, -1, 1, 2, -1, 1, 1, 1};
    vecs[0].o1   = '{0, 0, 0, 0, 0, 0, 0, 0};

    vecs[1].in_e = '{-32768, 100, 100, 100, 100, 100, 100, 100};
    vecs[1].in_o = '{-1, -1, -1, -1, -1, -1, -1, -1};
    vecs[1].e0   = '{100, -100, -100, -100, -100, -100, -100, -100};
    vecs[1].o0   = '{-1, -1, -1, -1, -1, -1, -1, -1};
    vecs[1].e1   = '{99, -99, -99, -99, -99, -99, -99, -99};
    vecs[1].o1   = '{0, 0, 0, 0, 0, 0, 0, 0};

    vecs[2].in_e = '{4, 4, 4, 4, 4, 4, 4, 4};
    vecs[2].in_o = '{3, 3, 9, 9, 9, 9, 9, 9};
    vecs[2].e0   = '{4, 4, 4, 4, 4, 4, 4, 4};
    vecs[2].o0   = '{3, 3, 3, 3, 3, 3, 3, 3};
    vecs[2].e1   = '{3, 3, 3, 3, 3, 3, 3, 3};
    vecs[2].o1   = '{2, 2, 2, 2, 2, 2, 2, 2};

    vecs[3].in_e = '{0, -5, 6, -7, 8, -9, 10, -11};
    vecs[3].in_o = '{-20, 15, -12, 30, -40, 12, 50, -60};
    vecs[3].e0   = '{5, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].o0   = '{-12, 12, -12, 12, -12, 12, 12, -12};
    vecs[3].e1   = '{4, 0, 0, 0, 0, 0, 0, 0};
    vecs[3].o1   = '{-11, 11, -11, 11, -11, 11, 11, -11};

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) run_pass(v, 32'h0, 0);

    // start during READ and WRITE must be ignored
    run_pass(0, (32'h1 << 3) | (32'h1 << 12), 0);
    // start on the DONE cycle is ignored; the very next cycle is accepted
    run_pass(1, 32'h1 << 18, 0);
    run_pass(2, 32'h0, 0);
    // reset in the middle of WRITE, then a clean pass
    run_pass(3, 32'h0, 12);
    @(negedge clk);
    run_pass(3, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
